// File: rtl/axi_lite_reg_writer_pkg.sv
// Shared definitions for the AXI4-Lite register write engine.
//   DATA_W / STRB_W : data bus and byte-strobe widths
//   ADDR_LSB        : lowest byte-address bit that selects a register
//   BRESP_OKAY      : the only write response this slave returns
//   IDLE..RESP      : write FSM state codes
//   strb_merge      : byte-strobe merge of new data into an old register value
package axi_lite_reg_writer_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned ADDR_LSB = DATA_W / 32 + 1;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    // Write FSM states
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HAVE_AW = 3'd1;
    localparam logic [2:0] HAVE_W  = 3'd2;
    localparam logic [2:0] COMMIT  = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    // Bytes with strobe set take new_data, the rest keep old_data
    function automatic logic [DATA_W-1:0] strb_merge(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_data;
        for (int k = 0; k < int'(STRB_W); k++) begin
            if (strb[k]) merged[8*k +: 8] = new_data[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_reg_writer.sv
// AXI4-Lite slave write channel for an eight-entry 32-bit register file.
// AW and W are accepted independently in either order, merged into the
// addressed register under WSTRB one cycle after the second handshake, and
// answered with an OKAY response held until BREADY.
// Ports:
//   clk, resetN                  clock (rising edge), async active-low reset
//   s_aw*, s_w*, s_b*            AXI4-Lite write address / data / response
//   r0..r7                       register file contents (to read-side mux)
//   wr_pulse                     one-cycle flag, bit i set when ri was updated
module axi_lite_reg_writer
    import axi_lite_reg_writer_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = DATA_W,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned OPT_MEM_ADDR_BITS  = 2
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                            s_awvalid,
    output logic                            s_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                            s_wvalid,
    output logic                            s_wready,
    output logic [1:0]                      s_bresp,
    output logic                            s_bvalid,
    input  logic                            s_bready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   r0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   r1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   r2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   r3,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   r4,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   r5,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   r6,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   r7,
    output logic [7:0]                      wr_pulse
);

    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned IDX_W = OPT_MEM_ADDR_BITS + 1;
    localparam int unsigned NREG  = 1 << IDX_W;

    logic [2:0]       state_q;
    logic [2:0]       state_nxt;
    logic             aw_hs;
    logic             w_hs;
    logic [IDX_W-1:0] idx_q;
    logic [DW-1:0]    wdata_q;
    logic [SW-1:0]    wstrb_q;
    logic [DW-1:0]    regs [NREG];

    // Sub-word address bits carry no register selection
    logic unused_addr_bits;
    assign unused_addr_bits = ^s_awaddr[ADDR_LSB-1:0];

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid  && s_wready;

    // Next-state decode
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (s_awvalid && s_wvalid) state_nxt = COMMIT;
                else if (s_awvalid)        state_nxt = HAVE_AW;
                else if (s_wvalid)         state_nxt = HAVE_W;
            end
            HAVE_AW: if (s_wvalid)  state_nxt = COMMIT;
            HAVE_W:  if (s_awvalid) state_nxt = COMMIT;
            COMMIT:  state_nxt = RESP;
            RESP:    if (s_bready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state so
    // they are Moore outputs straight off flops
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            s_bvalid  <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            s_awready <= (state_nxt == IDLE) || (state_nxt == HAVE_W);
            s_wready  <= (state_nxt == IDLE) || (state_nxt == HAVE_AW);
            s_bvalid  <= (state_nxt == RESP);
        end
    end

    // Payload holding registers so the master may move on after handshake
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (aw_hs) idx_q <= s_awaddr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
            if (w_hs) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
        end
    end

    // Register file update and write pulse on the edge leaving COMMIT
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (state_q == COMMIT) begin
                regs[idx_q] <= strb_merge(regs[idx_q], wdata_q, wstrb_q);
                if (wstrb_q != '0) wr_pulse <= 8'b1 << idx_q;
            end
        end
    end

    assign s_bresp = BRESP_OKAY;

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

endmodule

// File: tb/tb_axi_lite_reg_writer.sv
// Self-checking bench for axi_lite_reg_writer: a transaction-level model
// checked against the DUT every cycle, plus directed literal checks.
module tb_axi_lite_reg_writer;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [4:0]  s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0]  wr_pulse;

    always #5 clk = ~clk;

    axi_lite_reg_writer dut (
        .clk(clk), .resetN(resetN),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .wr_pulse(wr_pulse)
    );

    logic [31:0] dut_r [8];
    assign dut_r[0] = r0; assign dut_r[1] = r1; assign dut_r[2] = r2; assign dut_r[3] = r3;
    assign dut_r[4] = r4; assign dut_r[5] = r5; assign dut_r[6] = r6; assign dut_r[7] = r7;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one pending write, commit one cycle after both
    // halves arrive, response held until bready
    logic [31:0] m_reg [8];
    bit          m_have_aw, m_have_w, m_commit, m_resp;
    int          m_idx;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic [7:0]  m_pulse;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
            m_have_aw = 0; m_have_w = 0; m_commit = 0; m_resp = 0;
            m_idx = 0; m_data = 0; m_strb = 0; m_pulse = 0;
        end else begin
            m_pulse = 8'h0;
            if (m_commit) begin
                logic [31:0] mask;
                mask = 32'h0;
                for (int k = 0; k < 4; k++) if (m_strb[k]) mask = mask | (32'hFF << (8 * k));
                m_reg[m_idx] = (m_reg[m_idx] & ~mask) | (m_data & mask);
                if (m_strb != 4'h0) m_pulse = 8'(1 << m_idx);
                m_commit = 0;
                m_resp   = 1;
            end else if (m_resp) begin
                if (s_bready) m_resp = 0;
            end else begin
                if (s_awvalid && !m_have_aw) begin
                    m_have_aw = 1;
                    m_idx = (int'(s_awaddr) / 4) % 8;
                end
                if (s_wvalid && !m_have_w) begin
                    m_have_w = 1;
                    m_data = s_wdata;
                    m_strb = s_wstrb;
                end
                if (m_have_aw && m_have_w) begin
                    m_commit = 1; m_have_aw = 0; m_have_w = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit busy;
        busy = m_commit || m_resp;
        for (int i = 0; i < 8; i++) chk($sformatf("model_r%0d", i), 64'(dut_r[i]), 64'(m_reg[i]));
        chk("model_wr_pulse", 64'(wr_pulse), 64'(m_pulse));
        chk("model_bvalid",   64'(s_bvalid), 64'(m_resp));
        chk("model_bresp",    64'(s_bresp),  64'(2'b00));
        chk("model_awready",  64'(s_awready), 64'(!busy && !m_have_aw));
        chk("model_wready",   64'(s_wready),  64'(!busy && !m_have_w));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_aw(input logic [4:0] a);
        s_awaddr = a; s_awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_awready) begin
                @(posedge clk); #1;
                s_awvalid = 1'b0; s_awaddr = 5'h1F;
                return;
            end
        end
        chk("aw_handshake_timeout", 64'(1), 64'(0));
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_wready) begin
                @(posedge clk); #1;
                s_wvalid = 1'b0; s_wdata = 32'hBAD0BAD0; s_wstrb = 4'hF;
                return;
            end
        end
        chk("w_handshake_timeout", 64'(1), 64'(0));
        s_wvalid = 1'b0;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_bvalid && s_bready) begin
                step();
                return;
            end
        end
        chk("b_handshake_timeout", 64'(1), 64'(0));
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        s_bready = 1'b1;
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_resp();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        step();
        chk("reset_awready", 64'(s_awready), 64'(1));
        chk("reset_wready",  64'(s_wready),  64'(1));
        chk("reset_bvalid",  64'(s_bvalid),  64'(0));
        chk("reset_r2",      64'(r2),        64'(0));

        // AW and W together
        s_bready = 1'b0;
        fork
            send_aw(5'h08);
            send_w(32'hDEADBEEF, 4'hF);
        join
        chk("t1_commit_r2",     64'(r2),       64'(0));
        chk("t1_commit_bvalid", 64'(s_bvalid), 64'(0));
        step();
        chk("t1_r2",       64'(r2),       64'(32'hDEADBEEF));
        chk("t1_wr_pulse", 64'(wr_pulse), 64'(8'h04));
        chk("t1_bvalid",   64'(s_bvalid), 64'(1));
        step();
        chk("t1_pulse_clear", 64'(wr_pulse), 64'(0));
        chk("t1_bvalid_hold", 64'(s_bvalid), 64'(1));
        s_bready = 1'b1;
        wait_resp();
        chk("t1_bvalid_done", 64'(s_bvalid), 64'(0));

        // W first, AW three cycles later
        send_w(32'h12345678, 4'hF);
        chk("t2_wready_low", 64'(s_wready),  64'(0));
        chk("t2_awready",    64'(s_awready), 64'(1));
        repeat (2) step();
        send_aw(5'h1C);
        step();
        chk("t2_r7",     64'(r7),       64'(32'h12345678));
        chk("t2_bvalid", 64'(s_bvalid), 64'(1));
        wait_resp();
        step();
        chk("t2_single_resp", 64'(s_bvalid), 64'(0));

        // Partial strobe merge
        write(5'h0C, 32'hFFFFFFFF, 4'hF);
        write(5'h0C, 32'h00000000, 4'b0101);
        chk("t3_r3", 64'(r3), 64'(32'hFF00FF00));

        // Response backpressure with a second AW offered
        s_bready = 1'b0;
        fork
            send_aw(5'h14);
            send_w(32'h11112222, 4'hF);
        join
        step();
        s_awaddr = 5'h18; s_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_bvalid_hold", 64'(s_bvalid),  64'(1));
            chk("t4_awready_low", 64'(s_awready), 64'(0));
            chk("t4_wready_low",  64'(s_wready),  64'(0));
            step();
        end
        s_bready = 1'b1;
        wait_resp();
        send_aw(5'h18);
        send_w(32'h33334444, 4'hF);
        wait_resp();
        chk("t4_r5", 64'(r5), 64'(32'h11112222));
        chk("t4_r6", 64'(r6), 64'(32'h33334444));

        // Unaligned address, then an all-zero-strobe write
        write(5'h13, 32'hA5A5A5A5, 4'hF);
        chk("t5_r4", 64'(r4), 64'(32'hA5A5A5A5));
        fork
            send_aw(5'h10);
            send_w(32'hFFFFFFFF, 4'h0);
        join
        step();
        chk("t5_zero_pulse", 64'(wr_pulse), 64'(0));
        chk("t5_r4_hold",    64'(r4),       64'(32'hA5A5A5A5));
        chk("t5_bvalid",     64'(s_bvalid), 64'(1));
        chk("t5_bresp",      64'(s_bresp),  64'(0));
        wait_resp();

        // Reset while holding an address
        send_aw(5'h04);
        #3 resetN = 1'b0;
        #1;
        chk("t6_rst_r2",      64'(r2),        64'(0));
        chk("t6_rst_r4",      64'(r4),        64'(0));
        chk("t6_rst_bvalid",  64'(s_bvalid),  64'(0));
        chk("t6_rst_awready", 64'(s_awready), 64'(1));
        step();
        resetN = 1'b1;
        step();
        chk("t6_wready", 64'(s_wready), 64'(1));
        write(5'h04, 32'hCAFEF00D, 4'hF);
        chk("t6_r1", 64'(r1), 64'(32'hCAFEF00D));
        chk("t6_r2", 64'(r2), 64'(0));

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
